// File: rtl/dmi_pkg.sv
// Shared DMI definitions for the DTM, the DMI arbiter and the Debug Module.
package dmi_pkg;

    localparam int unsigned DMI_ADDR_W = 7;
    localparam int unsigned DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2
    } dmi_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } dmi_arb_state_t;

endpackage

// File: rtl/dmi_rr_pick.sv
// Two-way round-robin picker with owner lock for the DMI arbiter.
module dmi_rr_pick
    import dmi_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  logic       i_lock_valid,
    input  logic       i_owner,
    input  logic [1:0] i_lock,
    output logic       o_grant_valid,
    output logic       o_grant_idx
);

    logic [1:0] w_elig;

    always_comb begin
        w_elig = i_req;
        // A held lock masks the other port until the owner drops its lock input.
        if (i_lock_valid && i_lock[i_owner]) begin
            w_elig = i_req & (i_owner ? 2'b10 : 2'b01);
        end
        o_grant_valid = |w_elig;
        o_grant_idx   = (w_elig == 2'b11) ? ~i_last_grant : w_elig[1];
    end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares the Debug Module DMI target between the JTAG DTM (port 0) and the debug bridge (port 1).
module dmi_arbiter
    import dmi_pkg::*;
#(
    parameter int unsigned ADDR_W     = DMI_ADDR_W,
    parameter int unsigned DATA_W     = DMI_DATA_W,
    parameter int unsigned RD_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              dmi_read,
    output logic              dmi_write,
    output logic [ADDR_W-1:0] dmi_address,
    output logic [DATA_W-1:0] dmi_wdata,
    input  logic [DATA_W-1:0] dmi_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;

    dmi_arb_state_t     r_state;
    logic               r_last_grant;
    logic               r_lock_valid;
    logic               r_owner;
    logic               r_gnt;
    logic               r_we;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_grant_valid;
    logic               w_grant_idx;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_done;

    dmi_rr_pick u_pick (
        .i_req         ({m1_req, m0_req}),
        .i_last_grant  (r_last_grant),
        .i_lock_valid  (r_lock_valid),
        .i_owner       (r_owner),
        .i_lock        ({m1_lock, m0_lock}),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_we    = w_grant_idx ? m1_we    : m0_we;
    assign w_addr  = w_grant_idx ? m1_addr  : m0_addr;
    assign w_wdata = w_grant_idx ? m1_wdata : m0_wdata;

    // Last ISSUE/WAIT cycle: dmi_rdata is valid now and the ack follows next cycle.
    assign w_done = (RD_LATENCY == 0) ? (r_state == ISSUE)
                                      : ((r_state == WAIT) && (r_cnt == CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_lock_valid <= 1'b0;
            r_owner      <= 1'b0;
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            dmi_read     <= 1'b0;
            dmi_write    <= 1'b0;
            dmi_address  <= '0;
            dmi_wdata    <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_gnt        <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_we         <= w_we;
                        dmi_read     <= ~w_we;
                        dmi_write    <= w_we;
                        dmi_address  <= w_addr;
                        dmi_wdata    <= w_we ? w_wdata : '0;
                        busy         <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    dmi_read  <= 1'b0;
                    dmi_write <= 1'b0;
                    r_cnt     <= CNT_W'(RD_LATENCY);
                    r_state   <= w_done ? RESP : WAIT;
                end
                WAIT: begin
                    if (w_done) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    m0_ack       <= 1'b0;
                    m1_ack       <= 1'b0;
                    r_lock_valid <= r_gnt ? m1_lock : m0_lock;
                    r_owner      <= r_gnt;
                    dmi_address  <= '0;
                    dmi_wdata    <= '0;
                    busy         <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_done) begin
                m0_ack <= ~r_gnt;
                m1_ack <= r_gnt;
                if (!r_we) begin
                    if (r_gnt) begin
                        m1_rdata <= dmi_rdata;
                    end else begin
                        m0_rdata <= dmi_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: three instances (read latency 0, 2, 3), table vectors, directed
// corner sequences and random traffic against a transaction-level model.
module tb_dmi_arbiter;

    localparam logic [2:0][1:0] LATS   = {2'd3, 2'd2, 2'd0};
    localparam int              NRAND  = 3000;
    localparam logic [31:0]     RD_VAL = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;

    logic [2:0][1:0]       req, we, lock, ack;
    logic [2:0][1:0][6:0]  addr;
    logic [2:0][1:0][31:0] wdata, rdat;
    logic [2:0]            dm_rd, dm_wr, busy;
    logic [2:0][6:0]       dm_addr;
    logic [2:0][31:0]      dm_wd, dm_rdata;

    int n_cmp;
    int n_fail;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        dmi_arbiter #(
            .ADDR_W     (7),
            .DATA_W     (32),
            .RD_LATENCY (32'(LATS[k]))
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .m0_req      (req[k][0]),
            .m0_we       (we[k][0]),
            .m0_lock     (lock[k][0]),
            .m0_addr     (addr[k][0]),
            .m0_wdata    (wdata[k][0]),
            .m0_ack      (ack[k][0]),
            .m0_rdata    (rdat[k][0]),
            .m1_req      (req[k][1]),
            .m1_we       (we[k][1]),
            .m1_lock     (lock[k][1]),
            .m1_addr     (addr[k][1]),
            .m1_wdata    (wdata[k][1]),
            .m1_ack      (ack[k][1]),
            .m1_rdata    (rdat[k][1]),
            .dmi_read    (dm_rd[k]),
            .dmi_write   (dm_wr[k]),
            .dmi_address (dm_addr[k]),
            .dmi_wdata   (dm_wd[k]),
            .dmi_rdata   (dm_rdata[k]),
            .busy        (busy[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [1:0]  lock;
        bit          e_rd;
        bit          e_wr;
        logic [6:0]  e_addr;
        logic [1:0]  e_ack;
        bit          e_busy;
        logic [31:0] e_r0;
    } vec_t;

    vec_t vecs[$];

    // Transaction-level model state, one slot per instance.
    bit          m_act  [3];
    int          m_tg   [3];
    bit          m_g    [3];
    bit          m_we   [3];
    logic [6:0]  m_addr [3];
    logic [31:0] m_wd   [3];
    bit          m_last [3];
    bit          m_lv   [3];
    bit          m_own  [3];
    logic [31:0] m_rdat [3][2];
    bit          m_pend [3][2];
    bit          m_ackp [3][2];
    int          nstrobe[3];

    int          lt, ph, pt;
    bit          iss, rsp, bsy;
    logic [1:0]  eack, elig;

    function automatic int lat_of(int k);
        return int'(LATS[k]);
    endfunction

    function automatic vec_t mk(bit rs, logic [1:0] rq, logic [1:0] w, logic [1:0] lk, bit erd,
                                bit ewr, logic [6:0] ea, logic [1:0] eak, bit eb,
                                logic [31:0] er0);
        vec_t v;
        v.rst = rs; v.req = rq; v.we = w; v.lock = lk; v.e_rd = erd; v.e_wr = ewr;
        v.e_addr = ea; v.e_ack = eak; v.e_busy = eb; v.e_r0 = er0;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0; dm_rdata = '0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0; dm_rdata = '0;

        // Single read, then contention after reset, then owner lock and release (latency 0).
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 0, 0, 7'h00, 2'b00, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 1, 0, 7'h11, 2'b00, 1, 32'h0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 0, 0, 7'h11, 2'b01, 1, RD_VAL));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 7'h00, 2'b00, 0, RD_VAL));
        for (int c = 0; c < 25; c++) begin
            ph = c % 3;
            pt = (c / 3) % 2;
            vecs.push_back(mk(c == 0, {c < 24, c < 21}, 2'b10, 2'b00,
                              ph == 1 && pt == 0, ph == 1 && pt == 1,
                              (ph == 0) ? 7'h00 : ((pt == 1) ? 7'h22 : 7'h11),
                              (ph == 2) ? ((pt == 1) ? 2'b10 : 2'b01) : 2'b00,
                              ph != 0, (c >= 2) ? RD_VAL : 32'h0));
        end
        for (int c = 0; c < 9; c++) begin
            ph = c % 3;
            vecs.push_back(mk(0, 2'b11, 2'b10, 2'b01, ph == 1, 0,
                              (ph == 0) ? 7'h00 : 7'h11, (ph == 2) ? 2'b01 : 2'b00,
                              ph != 0, RD_VAL));
        end
        vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, 0, 0, 7'h00, 2'b00, 0, RD_VAL));
        vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, 0, 1, 7'h22, 2'b00, 1, RD_VAL));
        vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, 0, 0, 7'h22, 2'b10, 1, RD_VAL));
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, 0, 0, 7'h00, 2'b00, 0, RD_VAL));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset;
            else tick;
            chk($sformatf("tbl[%0d] dmi_read", i), 64'(dm_rd[0]), 64'(vecs[i].e_rd));
            chk($sformatf("tbl[%0d] dmi_write", i), 64'(dm_wr[0]), 64'(vecs[i].e_wr));
            chk($sformatf("tbl[%0d] dmi_address", i), 64'(dm_addr[0]), 64'(vecs[i].e_addr));
            chk($sformatf("tbl[%0d] ack", i), 64'(ack[0]), 64'(vecs[i].e_ack));
            chk($sformatf("tbl[%0d] busy", i), 64'(busy[0]), 64'(vecs[i].e_busy));
            chk($sformatf("tbl[%0d] m0_rdata", i), 64'(rdat[0][0]), 64'(vecs[i].e_r0));
            chk($sformatf("tbl[%0d] m1_rdata", i), 64'(rdat[0][1]), 64'(32'h0));
            req[0] = vecs[i].req;
            we[0] = vecs[i].we;
            lock[0] = vecs[i].lock;
            addr[0][0] = 7'h11;
            addr[0][1] = 7'h22;
            wdata[0][0] = 32'h0;
            wdata[0][1] = 32'h0BAD_C0DE;
            dm_rdata[0] = RD_VAL;
        end

        // Port 1 write with read latency 2.
        do_reset;
        dm_rdata[1] = 32'hAAAA_5555;
        req[1] = 2'b10; we[1] = 2'b10; addr[1][1] = 7'h10; wdata[1][1] = 32'h1234_5678;
        tick;
        chk("wr strobe", 64'({dm_wr[1], dm_rd[1]}), 64'(2'b10));
        chk("wr address", 64'(dm_addr[1]), 64'(7'h10));
        chk("wr wdata", 64'(dm_wd[1]), 64'(32'h1234_5678));
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("wr wait strobe", 64'({dm_wr[1], dm_rd[1]}), 64'(2'b00));
            chk("wr wait ack", 64'(ack[1]), 64'(2'b00));
            chk("wr wait busy", 64'(busy[1]), 64'(1'b1));
        end
        tick;
        chk("wr ack", 64'(ack[1]), 64'(2'b10));
        chk("wr m1_rdata kept", 64'(rdat[1][1]), 64'(32'h0));
        req[1] = 2'b00;
        tick;
        chk("wr idle busy", 64'(busy[1]), 64'(1'b0));
        chk("wr idle address", 64'(dm_addr[1]), 64'(7'h0));

        // Reset during WAIT with read latency 3, then a clean read.
        do_reset;
        dm_rdata[2] = 32'h5A5A_5A5A;
        req[2] = 2'b01; addr[2][0] = 7'h33;
        tick;
        chk("rst pre strobe", 64'(dm_rd[2]), 64'(1'b1));
        tick;
        rst_n = 1'b0;
        #1;
        chk("rst strobes", 64'({dm_wr[2], dm_rd[2]}), 64'(2'b00));
        chk("rst busy", 64'(busy[2]), 64'(1'b0));
        chk("rst ack", 64'(ack[2]), 64'(2'b00));
        req[2] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst hold ack", 64'(ack[2]), 64'(2'b00));
        end
        rst_n = 1'b1;
        tick;
        chk("rst after ack", 64'(ack[2]), 64'(2'b00));
        chk("rst after rdata", 64'(rdat[2][0]), 64'(32'h0));
        dm_rdata[2] = 32'hCAFE_F00D;
        req[2] = 2'b01; addr[2][0] = 7'h34;
        tick;
        chk("rst new strobe", 64'({dm_wr[2], dm_rd[2]}), 64'(2'b01));
        chk("rst new address", 64'(dm_addr[2]), 64'(7'h34));
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst new wait ack", 64'(ack[2]), 64'(2'b00));
        end
        tick;
        chk("rst new ack", 64'(ack[2]), 64'(2'b01));
        chk("rst new rdata", 64'(rdat[2][0]), 64'(32'hCAFE_F00D));
        req[2] = 2'b00;
        tick;
        chk("rst new idle", 64'(busy[2]), 64'(1'b0));

        // Random traffic on all three instances against the model.
        do_reset;
        for (int k = 0; k < 3; k++) begin
            m_act[k] = 0; m_last[k] = 1; m_lv[k] = 0; m_own[k] = 0; nstrobe[k] = 0;
            for (int p = 0; p < 2; p++) begin
                m_rdat[k][p] = '0; m_pend[k][p] = 0; m_ackp[k][p] = 0;
            end
        end
        for (int t = 0; t < NRAND; t++) begin
            if (t > 0) tick;
            for (int k = 0; k < 3; k++) begin
                lt   = lat_of(k);
                iss  = m_act[k] && (t == m_tg[k] + 1);
                rsp  = m_act[k] && (t == m_tg[k] + 2 + lt);
                bsy  = m_act[k] && (t > m_tg[k]);
                eack = rsp ? (m_g[k] ? 2'b10 : 2'b01) : 2'b00;
                chk("rnd dmi_read", 64'(dm_rd[k]), 64'(iss && !m_we[k]));
                chk("rnd dmi_write", 64'(dm_wr[k]), 64'(iss && m_we[k]));
                chk("rnd dmi_address", 64'(dm_addr[k]), 64'(bsy ? m_addr[k] : 7'h0));
                chk("rnd busy", 64'(busy[k]), 64'(bsy));
                chk("rnd ack", 64'(ack[k]), 64'(eack));
                chk("rnd m0_rdata", 64'(rdat[k][0]), 64'(m_rdat[k][0]));
                chk("rnd m1_rdata", 64'(rdat[k][1]), 64'(m_rdat[k][1]));
                if (iss) chk("rnd dmi_wdata", 64'(dm_wd[k]), 64'(m_we[k] ? m_wd[k] : 32'h0));
                chk("rnd read&write", 64'(dm_rd[k] & dm_wr[k]), 64'(1'b0));
                chk("rnd ack w/o req", 64'(ack[k] & ~req[k]), 64'(2'b00));
                if (dm_rd[k] || dm_wr[k]) nstrobe[k]++;
                if (|ack[k]) begin
                    chk("rnd strobes per ack", 64'(nstrobe[k]), 64'(1));
                    nstrobe[k] = 0;
                end

                for (int p = 0; p < 2; p++) begin
                    if (m_ackp[k][p]) m_pend[k][p] = 0;
                    if (!m_pend[k][p] && $urandom_range(2) == 0) begin
                        m_pend[k][p] = 1;
                        we[k][p]     = 1'($urandom_range(1));
                        addr[k][p]   = 7'($urandom);
                        wdata[k][p]  = $urandom;
                    end
                    req[k][p]    = m_pend[k][p];
                    lock[k][p]   = ($urandom_range(3) == 0);
                    m_ackp[k][p] = eack[p];
                end
                dm_rdata[k] = $urandom;

                if (m_act[k] && (t == m_tg[k] + 1 + lt) && !m_we[k]) begin
                    m_rdat[k][m_g[k]] = dm_rdata[k];
                end
                if (rsp) begin
                    m_lv[k]  = lock[k][m_g[k]];
                    m_own[k] = m_g[k];
                    m_act[k] = 0;
                end else if (!m_act[k]) begin
                    elig = req[k];
                    if (m_lv[k] && lock[k][m_own[k]]) elig = elig & (2'b01 << m_own[k]);
                    if (elig != 2'b00) begin
                        m_g[k]    = (elig == 2'b11) ? !m_last[k] : elig[1];
                        m_last[k] = m_g[k];
                        m_act[k]  = 1;
                        m_tg[k]   = t;
                        m_we[k]   = we[k][m_g[k]];
                        m_addr[k] = addr[k][m_g[k]];
                        m_wd[k]   = wdata[k][m_g[k]];
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
- Shares the single DMI target port of the Debug Module between two requesters: port 0 is the JTAG DTM and port 1 is the secondary debug bridge.
- Per-port protocol is level req / pulse ack.
- Arbitration is round-robin with an optional per-owner lock, so multi-access sequences stay atomic.
- Issues exactly one registered read/write strobe per granted request, captures read data after a fixed latency, and returns it with the ack.

Parameters:
ADDR_W, 7, DMI address width
DATA_W, 32, DMI data width
RD_LATENCY, 0, cycles between the strobe cycle and the cycle in which dmi_rdata is valid (0 = same cycle as strobe)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
m0_req  in  1  port 0 request; held high until m0_ack
m0_we  in  1  port 0: 1 = write, 0 = read; stable while m0_req high
m0_lock  in  1  port 0 requests to keep the grant after this access
m0_addr  in  ADDR_W  port 0 DMI address
m0_wdata  in  DATA_W  port 0 write data
m0_ack  out  1  port 0 completion pulse
m0_rdata  out  DATA_W  port 0 read data, valid with m0_ack
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1
dmi_read  out  1  one-cycle read strobe to DM
dmi_write  out  1  one-cycle write strobe to DM
dmi_address  out  ADDR_W  DM address
dmi_wdata  out  DATA_W  DM write data
dmi_rdata  in  DATA_W  DM read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; m*_rdata cleared to 0; last_grant = 1, so port 0 wins the first tie; lock_valid = 0.
- FSM states: IDLE -> ISSUE -> WAIT (only if RD_LATENCY > 0) -> RESP -> IDLE.
- IDLE, candidate selection:
  - If lock_valid and the owner's lock input is high, only the owner's req is eligible.
  - Otherwise both requests are eligible.
  - Both eligible and high: grant the port != last_grant.
  - One high: grant that port.
- IDLE, on grant: latch we/addr/wdata; set last_grant; go to ISSUE. With no grant, stay in IDLE.
- ISSUE: exactly one cycle.
  - dmi_write = latched we; dmi_read = !latched we.
  - dmi_address and dmi_wdata come from the latch. dmi_wdata is 0 for reads.
  - A down-counter is loaded with RD_LATENCY.
- WAIT: decrement the counter; move to RESP when the counter reaches 1.
- Read data capture: dmi_rdata is sampled into the granted port's m*_rdata on the last ISSUE/WAIT cycle (cycle ISSUE+RD_LATENCY). Writes leave m*_rdata unchanged.
- RESP: one-cycle ack to the granted port.
  - lock_valid <= granted port's lock input; owner <= granted port.
  - Go to IDLE.
- Latency: req first high in IDLE cycle N -> strobe in N+1 -> ack in N+2+RD_LATENCY. Reads and writes have identical timing.
- dmi_address is held from ISSUE through RESP and forced to 0 in IDLE. dmi_read and dmi_write are never high together and never high outside ISSUE.
- Requester rule: drop req (or present the next request) on the cycle after ack. Any request present in the IDLE cycle after RESP is treated as new.
- m*_rdata holds its value until the next read completion on that port.
- Lock release: the owner drops its lock input. This is evaluated in IDLE, and the other port becomes eligible in that same IDLE cycle.
- Lock idle case: if the owner keeps lock high without req, the other port starves. This is intended and documented for software.
- Reset mid-operation aborts the access immediately: no ack, strobes deassert asynchronously.
- Simultaneous req rise on both ports in IDLE: round-robin decides; the loser is served in the next IDLE with no request lost.

Decomposition:
- Shared package dmi_pkg:
  - DMI_ADDR_W = 7, DMI_DATA_W = 32
  - op encodings NOP/READ/WRITE = 0/1/2 (shared with the DTM)
  - typedef dmi_arb_state_t {IDLE, ISSUE, WAIT, RESP}
- Sub-module dmi_rr_pick: combinational 2-way round-robin picker. Inputs: req[1:0], last_grant, lock_valid, owner, lock[1:0]. Outputs: grant_valid, grant_idx.
- FSM, latch and counter stay in dmi_arbiter.

Test Plan:
- Single read, RD_LATENCY=0: m0_req, we=0, addr=0x11, DM returns 0xDEADBEEF -> dmi_read pulse at N+1 with dmi_address=0x11; m0_ack at N+2; m0_rdata=0xDEADBEEF; m1 signals idle.
- Write, RD_LATENCY=2: m1 writes 0x12345678 to 0x10 -> dmi_write at N+1 with dmi_wdata=0x12345678; m1_ack at N+4; m1_rdata unchanged.
- Contention after reset: m0 and m1 req simultaneously, 4 accesses each, back-to-back -> grants alternate 0,1,0,1,...; each strobe is separated by the full ISSUE..RESP sequence.
- Lock: m0 holds lock across 3 reads while m1_req is high -> three m0 acks, no m1 strobe. m0 then drops lock -> m1 is served next.
- Reset mid-operation: assert rst_n low during WAIT (RD_LATENCY=3) -> no ack; strobes and busy at 0; after release, a new m0 request completes normally.
- Assertion checks over random traffic:
  - dmi_read and dmi_write are never high together.
  - Each ack is preceded by exactly one strobe.
  - No ack without req.
